// File: rtl/ufifo.sv
// rtl/ufifo.sv - first-word-fall-through FIFO with registered status, used count and error pulse.
// Capacity is 2^LGFLEN-1; the head word comes from a bypass register or a registered array read.
module ufifo #(
  parameter int BW     = 8,
  parameter int LGFLEN = 2
) (
  input  logic              i_clk,
  input  logic              i_reset,
  input  logic              i_wr,
  input  logic [BW-1:0]     i_data,
  input  logic              i_rd,
  output logic [BW-1:0]     o_data,
  output logic              o_empty,
  output logic              o_full,
  output logic [LGFLEN-1:0] o_used,
  output logic              o_err
);

  localparam int DEPTH = 1 << LGFLEN;
  localparam logic [LGFLEN-1:0] MAX_USED = LGFLEN'(DEPTH - 1);

  logic [BW-1:0]     mem [DEPTH];

  logic [LGFLEN-1:0] wr_addr_q, wr_addr_d;
  logic [LGFLEN-1:0] rd_addr_q, rd_addr_d;
  logic [LGFLEN-1:0] used_q, used_d;
  logic              empty_q, empty_d;
  logic              full_q, full_d;
  logic              err_q, err_d;
  logic              byp_sel_q, byp_sel_d;
  logic [BW-1:0]     byp_data_q, byp_data_d;
  logic [BW-1:0]     rd_data_q, rd_data_d;
  logic              wr_ok, rd_ok;

  always_comb begin
    rd_ok = i_rd && !empty_q;
    // A full FIFO still takes a write when the same edge pops the head.
    wr_ok = i_wr && (!full_q || i_rd);
    err_d = (i_rd && empty_q) || (i_wr && full_q && !i_rd);

    wr_addr_d = wr_addr_q + {{(LGFLEN-1){1'b0}}, wr_ok};
    rd_addr_d = rd_addr_q + {{(LGFLEN-1){1'b0}}, rd_ok};
    used_d    = wr_addr_d - rd_addr_d;
    empty_d   = (used_d == '0);
    full_d    = (used_d == MAX_USED);

    byp_sel_d  = byp_sel_q;
    byp_data_d = byp_data_q;
    rd_data_d  = rd_data_q;
    // Writing straight into the next head slot: the array has not been written yet, so bypass.
    if (wr_ok && (wr_addr_q == rd_addr_d)) begin
      byp_sel_d  = 1'b1;
      byp_data_d = i_data;
    end else if (!empty_d) begin
      byp_sel_d = 1'b0;
      rd_data_d = mem[rd_addr_d];
    end
  end

  always_ff @(posedge i_clk or posedge i_reset) begin
    if (i_reset) begin
      wr_addr_q  <= '0;
      rd_addr_q  <= '0;
      used_q     <= '0;
      empty_q    <= 1'b1;
      full_q     <= 1'b0;
      err_q      <= 1'b0;
      byp_sel_q  <= 1'b0;
      byp_data_q <= '0;
      rd_data_q  <= '0;
    end else begin
      wr_addr_q  <= wr_addr_d;
      rd_addr_q  <= rd_addr_d;
      used_q     <= used_d;
      empty_q    <= empty_d;
      full_q     <= full_d;
      err_q      <= err_d;
      byp_sel_q  <= byp_sel_d;
      byp_data_q <= byp_data_d;
      rd_data_q  <= rd_data_d;
    end
  end

  always_ff @(posedge i_clk) begin
    if (wr_ok) mem[wr_addr_q] <= i_data;
  end

  assign o_data  = byp_sel_q ? byp_data_q : rd_data_q;
  assign o_empty = empty_q;
  assign o_full  = full_q;
  assign o_used  = used_q;
  assign o_err   = err_q;

endmodule

// File: tb/tb_ufifo.sv
// tb/tb_ufifo.sv - directed and randomized checks of ufifo against a queue-based reference model.
module tb_ufifo;
  localparam int BW     = 8;
  localparam int LGFLEN = 2;
  localparam int CAP    = (1 << LGFLEN) - 1;

  logic              clk = 1'b0;
  logic              rst;
  logic              i_wr, i_rd;
  logic [BW-1:0]     i_data;
  logic [BW-1:0]     o_data;
  logic              o_empty, o_full, o_err;
  logic [LGFLEN-1:0] o_used;

  int                n_vec  = 0;
  int                n_miss = 0;
  logic [BW-1:0]     model_q[$];
  logic              exp_err;

  ufifo #(.BW(BW), .LGFLEN(LGFLEN)) dut (
    .i_clk(clk), .i_reset(rst), .i_wr(i_wr), .i_data(i_data), .i_rd(i_rd),
    .o_data(o_data), .o_empty(o_empty), .o_full(o_full), .o_used(o_used), .o_err(o_err)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_miss++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  task automatic check_state();
    chk("used", 32'(o_used), 32'(model_q.size()));
    chk("empty", 32'(o_empty), 32'(model_q.size() == 0));
    chk("full", 32'(o_full), 32'(model_q.size() == CAP));
    chk("err", 32'(o_err), 32'(exp_err));
    if (model_q.size() > 0) chk("head", 32'(o_data), 32'(model_q[0]));
  endtask

  // One clock: drive, check popped value, model the edge, then check all outputs.
  task automatic cycle(input logic wr, input logic rd, input logic [BW-1:0] d);
    bit was_empty, was_full;
    i_wr = wr; i_rd = rd; i_data = d;
    if (rd && model_q.size() > 0) chk("rd_data", 32'(o_data), 32'(model_q[0]));
    @(posedge clk);
    was_empty = (model_q.size() == 0);
    was_full  = (model_q.size() == CAP);
    exp_err   = (rd && was_empty) || (wr && was_full && !rd);
    if (rd && !was_empty) void'(model_q.pop_front());
    if (wr && (!was_full || rd)) model_q.push_back(d);
    #1;
    check_state();
    i_wr = 1'b0; i_rd = 1'b0;
  endtask

  // Called 1 time unit after a rising edge; reset pulses entirely between edges.
  task automatic mid_reset();
    #3 rst = 1'b1;
    #1;
    model_q.delete();
    exp_err = 1'b0;
    chk("rst_used", 32'(o_used), 32'd0);
    chk("rst_empty", 32'(o_empty), 32'd1);
    chk("rst_full", 32'(o_full), 32'd0);
    chk("rst_err", 32'(o_err), 32'd0);
    chk("rst_data", 32'(o_data), 32'd0);
    #2 rst = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL timeout: simulation did not complete");
    $fatal(1, "timeout");
  end

  initial begin
    rst = 1'b1; i_wr = 1'b0; i_rd = 1'b0; i_data = '0; exp_err = 1'b0;
    #3;
    check_state();
    chk("rst_data0", 32'(o_data), 32'd0);
    @(posedge clk);
    #1 rst = 1'b0;

    // Fill with zeros, drain, idle.
    repeat (3) cycle(1'b1, 1'b0, 8'h00);
    for (int i = 0; i < 3; i++) begin
      cycle(1'b0, 1'b1, 8'h00);
      chk("drain_data", 32'(o_data), 32'd0);
    end
    cycle(1'b0, 1'b0, 8'h00);

    // Ordering with fall-through visibility.
    cycle(1'b1, 1'b0, 8'hA1);
    chk("fwft_a1", 32'(o_data), 32'hA1);
    cycle(1'b1, 1'b0, 8'hB2);
    cycle(1'b1, 1'b0, 8'hC3);
    repeat (3) cycle(1'b0, 1'b1, 8'h00);

    // Error cases.
    cycle(1'b0, 1'b1, 8'h00);
    cycle(1'b0, 1'b0, 8'h00);
    cycle(1'b1, 1'b1, 8'h5A);
    repeat (2) cycle(1'b1, 1'b0, 8'h11);
    cycle(1'b1, 1'b0, 8'h22);
    cycle(1'b1, 1'b0, 8'hFF);
    cycle(1'b1, 1'b1, 8'hEE);
    repeat (3) cycle(1'b0, 1'b1, 8'h00);

    // Wrap: alternating write/read pairs.
    for (int i = 0; i < 10; i++) begin
      cycle(1'b1, 1'b0, 8'(8'h30 + i));
      cycle(1'b0, 1'b1, 8'h00);
    end

    // Asynchronous reset with two entries queued.
    cycle(1'b1, 1'b0, 8'h01);
    cycle(1'b1, 1'b0, 8'h02);
    mid_reset();
    cycle(1'b0, 1'b0, 8'h00);
    cycle(1'b1, 1'b0, 8'h55);
    cycle(1'b1, 1'b1, 8'h66);

    // Randomized traffic with occasional reset.
    for (int i = 0; i < 3000; i++) begin
      if ($urandom_range(0, 199) == 0) mid_reset();
      cycle(1'($urandom_range(0, 99) < 55), 1'($urandom_range(0, 99) < 50), 8'($urandom));
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
    $finish;
  end
endmodule

// File: doc/ufifo.md
UFIFO -- requirements
Module: ufifo

Interface

Parameters:
- REQ-001: BW, default 8, data width in bits.
- REQ-002: LGFLEN, default 2, log2 of storage array depth; usable capacity SHALL be 2^LGFLEN-1 entries (3 at default).

Ports (name, direction, width, meaning):
- REQ-003: i_clk, input, 1, the single clock; all state updates on its rising edge.
- REQ-004: i_reset, input, 1, reset, asynchronous and active-high.
- REQ-005: i_wr, input, 1, write request.
- REQ-006: i_data, input, BW, write data, sampled with i_wr.
- REQ-007: i_rd, input, 1, read (pop) request.
- REQ-008: o_data, output, BW, head-of-queue data, first-word-fall-through.
- REQ-009: o_empty, output, 1, high when the FIFO holds 0 entries.
- REQ-010: o_full, output, 1, high when the FIFO holds 2^LGFLEN-1 entries.
- REQ-011: o_used, output, LGFLEN, current entry count, range 0..2^LGFLEN-1.
- REQ-012: o_err, output, 1, registered one-cycle error pulse.

Function
- REQ-013: Storage SHALL be a 2^LGFLEN x BW array addressed by wr_addr and rd_addr, both LGFLEN bits wide and wrapping modulo 2^LGFLEN.
- REQ-014: full SHALL be defined as wr_addr+1 == rd_addr (mod 2^LGFLEN); empty SHALL be defined as wr_addr == rd_addr.
- REQ-015: A write SHALL be accepted when i_wr=1 and either (not full) or (full and i_rd=1). On acceptance: store i_data at wr_addr, then wr_addr increments.
- REQ-016: A read SHALL be accepted when i_rd=1 and not empty; rd_addr increments.
- REQ-017: Emptiness is judged before the current write. A read while empty is an underflow even if i_wr=1 in the same cycle; that write is still accepted.
- REQ-018: A write while full without i_rd is an overflow; the write is dropped and no state changes.
- REQ-019: o_err SHALL be 1 in the cycle after any overflow or underflow, else 0.
- REQ-020: o_used SHALL update in the cycle after each edge:
  - +1 on write only;
  - -1 on read only;
  - unchanged on simultaneous accepted read and write, or when nothing is accepted.
- REQ-021: o_empty and o_full SHALL be registered and consistent with o_used after every edge.
- REQ-022: o_data SHALL equal the entry at rd_addr whenever o_empty=0, with zero extra latency:
  - data written at edge k SHALL appear on o_data after edge k if the FIFO was empty;
  - this SHALL be implemented with a bypass register selected when writing into an empty or emptying FIFO.
- REQ-023: While o_empty=1, o_data SHALL hold its last value; its value is don't-care to the consumer.
- REQ-024: Ordering SHALL be strict FIFO; pointers wrap seamlessly across the array boundary.

Reset
- REQ-025: Asserting i_reset SHALL immediately, independent of i_clk, force:
  - wr_addr=0, rd_addr=0;
  - o_used=0, o_empty=1, o_full=0;
  - o_err=0, o_data=0, bypass select cleared.
- REQ-026: Array contents are not reset.
- REQ-027: Reset asserted mid-operation SHALL discard all queued data; the first edge after deassertion behaves as on an empty FIFO.

Verification
- REQ-028: Fill: after reset, i_wr=1 with data 0x00 for 3 cycles, i_rd=0 -> o_used 1,2,3; o_full=1 after the third edge; o_err=0.
- REQ-029: Drain: continuing from REQ-028, i_rd=1 for 3 cycles, i_wr=0 -> o_used 2,1,0; o_empty=1 after the third read; o_data=0x00 throughout; o_err=0. Then idle one cycle -> no change.
- REQ-030: Ordering: write 0xA1,0xB2,0xC3, then read 3 -> o_data shows 0xA1, 0xB2, 0xC3 in order; 0xA1 is visible the cycle after its write.
- REQ-031: Errors:
  - read on empty -> o_err=1 for one cycle, o_used stays 0;
  - write on full with i_rd=0 -> o_err=1, o_used stays 3, data dropped;
  - full with i_rd=1 and i_wr=1 -> no error, o_used stays 3.
- REQ-032: Wrap: 10 alternating write/read pairs with incrementing data -> every read returns the matching value; no o_err.
- REQ-033: Async reset: with 2 entries queued, pulse i_reset between clock edges -> o_empty=1 and o_used=0 before the next edge.
